// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for data_mem_responder: MMIO register offsets, CTRL/STATUS
// bit positions and the address-region type used by the decoder.
package data_mem_responder_pkg;

  // Byte offsets of the timer registers inside the 256-byte MMIO window
  localparam logic [7:0] OffCtrl     = 8'h00;
  localparam logic [7:0] OffLoad     = 8'h04;
  localparam logic [7:0] OffCount    = 8'h08;
  localparam logic [7:0] OffStatus   = 8'h0C;
  localparam logic [7:0] OffPrescale = 8'h10;

  // CTRL and STATUS bit positions
  localparam int unsigned CtrlEnBit     = 0;
  localparam int unsigned CtrlReloadBit = 1;
  localparam int unsigned CtrlIeBit     = 2;
  localparam int unsigned StatusPendBit = 0;

  typedef enum logic [1:0] {
    SelRam,
    SelMmio,
    SelMiss
  } region_e;

  // Word-aligned byte offset from address bits [7:2]
  function automatic logic [7:0] word_off(input logic [5:0] word);
    return {word, 2'b00};
  endfunction

endpackage

// File: rtl/data_mem_responder_irq_timer.sv
// Down-counting MMIO timer with pending flag and registered interrupt output.
// Optional prescaler enabled by defining TIMER_PRESCALE_EN.
module data_mem_responder_irq_timer
  import data_mem_responder_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_wen,
  input  logic [7:0]  bus_off,
  input  logic [31:0] bus_wdata,
  output logic [31:0] rdata,
  output logic        interrupter
);

  logic        en_q, en_d;
  logic        reload_q, reload_d;
  logic        ie_q, ie_d;
  logic [31:0] load_q, load_d;
  logic [31:0] count_q, count_d;
  logic        pend_q, pend_d;
  logic        irq_q, irq_d;
  logic        tick;
  logic        expire;

  logic wr_ctrl, wr_load, wr_status;
  assign wr_ctrl   = bus_wen && (bus_off == OffCtrl);
  assign wr_load   = bus_wen && (bus_off == OffLoad);
  assign wr_status = bus_wen && (bus_off == OffStatus);

`ifdef TIMER_PRESCALE_EN
  logic        wr_psc;
  logic [15:0] psc_q, psc_d;
  logic [15:0] pcnt_q, pcnt_d;
  assign wr_psc = bus_wen && (bus_off == OffPrescale);
  assign tick   = en_q && (pcnt_q == psc_q);

  // Prescale counter restarts on CTRL/LOAD writes, while disabled and after each tick
  always_comb begin
    pcnt_d = pcnt_q + 16'd1;
    if (!en_q || wr_ctrl || wr_load || tick) pcnt_d = '0;
    psc_d = wr_psc ? bus_wdata[15:0] : psc_q;
  end
`else
  assign tick = en_q;
`endif

  // Timer state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_q     <= 1'b0;
      reload_q <= 1'b0;
      ie_q     <= 1'b0;
      load_q   <= '0;
      count_q  <= '0;
      pend_q   <= 1'b0;
      irq_q    <= 1'b0;
`ifdef TIMER_PRESCALE_EN
      psc_q    <= '0;
      pcnt_q   <= '0;
`endif
    end else begin
      en_q     <= en_d;
      reload_q <= reload_d;
      ie_q     <= ie_d;
      load_q   <= load_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
      irq_q    <= irq_d;
`ifdef TIMER_PRESCALE_EN
      psc_q    <= psc_d;
      pcnt_q   <= pcnt_d;
`endif
    end
  end

  // Next state: timer action first, bus writes override, expiry beats a PEND clear
  always_comb begin
    en_d     = en_q;
    reload_d = reload_q;
    ie_d     = ie_q;
    load_d   = load_q;
    count_d  = count_q;
    pend_d   = pend_q;
    expire   = 1'b0;

    if (tick) begin
      if (count_q != '0) begin
        count_d = count_q - 32'd1;
      end else begin
        expire = 1'b1;
        pend_d = 1'b1;
        if (reload_q) count_d = load_q;
        else          en_d    = 1'b0;
      end
    end

    if (wr_ctrl) begin
      en_d     = bus_wdata[CtrlEnBit];
      reload_d = bus_wdata[CtrlReloadBit];
      ie_d     = bus_wdata[CtrlIeBit];
    end
    if (wr_load) begin
      load_d  = bus_wdata;
      count_d = bus_wdata;
    end
    if (wr_status && bus_wdata[StatusPendBit] && !expire) pend_d = 1'b0;

    // Registered from current state so the bus never reaches interrupter combinationally
    irq_d = pend_q && ie_q;
  end

  // Register read mux
  always_comb begin
    rdata = '0;
    case (bus_off)
      OffCtrl: begin
        rdata[CtrlEnBit]     = en_q;
        rdata[CtrlReloadBit] = reload_q;
        rdata[CtrlIeBit]     = ie_q;
      end
      OffLoad:     rdata = load_q;
      OffCount:    rdata = count_q;
      OffStatus:   rdata[StatusPendBit] = pend_q;
`ifdef TIMER_PRESCALE_EN
      OffPrescale: rdata = {16'h0, psc_q};
`endif
      default:     rdata = '0;
    endcase
  end

  assign interrupter = irq_q;

endmodule

// File: rtl/data_mem_responder.sv
// Data-side memory responder: zero-wait word RAM, MMIO timer window and a sticky
// bus error flag for accesses that hit neither. Optional timer prescaler is
// enabled by defining TIMER_PRESCALE_EN.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned RAM_AW    = 10,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_FF00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_dout,
  output logic [31:0] mem_din,
  output logic        interrupter,
  output logic        bus_err
);

  localparam int unsigned RamDepth = 1 << RAM_AW;

  logic [31:0]       ram [RamDepth];
  logic [RAM_AW-1:0] ram_idx;
  region_e           region;
  logic [7:0]        mmio_off;
  logic [31:0]       mmio_rdata;
  logic              bus_err_q;

  // Byte lanes are not supported; the low address bits are don't-care
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^mem_addr[1:0];

  assign ram_idx  = mem_addr[RAM_AW+1:2];
  assign mmio_off = word_off(mem_addr[7:2]);

  // Address decode
  always_comb begin
    if (mem_addr[31:RAM_AW+2] == '0)            region = SelRam;
    else if (mem_addr[31:8] == MMIO_BASE[31:8]) region = SelMmio;
    else                                        region = SelMiss;
  end

  data_mem_responder_irq_timer u_timer (
    .clk         (clk),
    .rst         (rst),
    .bus_wen     (mem_wen && (region == SelMmio)),
    .bus_off     (mmio_off),
    .bus_wdata   (mem_dout),
    .rdata       (mmio_rdata),
    .interrupter (interrupter)
  );

  // RAM write port; contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (mem_wen && (region == SelRam)) ram[ram_idx] <= mem_dout;
  end

  // Sticky error on any access outside RAM and MMIO
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_err_q <= 1'b0;
    end else if ((mem_ren || mem_wen) && (region == SelMiss)) begin
      bus_err_q <= 1'b1;
    end
  end

  // Zero-wait read mux; a same-cycle write is seen only from the next cycle
  always_comb begin
    mem_din = '0;
    if (mem_ren) begin
      case (region)
        SelRam:  mem_din = ram[ram_idx];
        SelMmio: mem_din = mmio_rdata;
        default: mem_din = '0;
      endcase
    end
  end

  assign bus_err = bus_err_q;

endmodule
